// File: rtl/serial_memory_responder.sv
// Bit-serial 16-bit word store: collects a 25-bit request frame, waits LATENCY cycles,
// performs a byte write / word read, then streams the word back LSB first.
// Optional read/write counters are compiled in with RESPONDER_STATS_EN.
module serial_memory_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic        fast_clk,
  input  logic        reset,
  input  logic        request_serial,
  input  logic        request_serial_ready,
  output logic        response_serial,
  output logic        response_serial_ready,
  output logic        busy,
  output logic        frame_error
`ifdef RESPONDER_STATS_EN
  ,
  output logic [15:0] read_count,
  output logic [15:0] write_count
`endif
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT       = 4'(LATENCY);
  localparam logic [4:0] FRAME_LEN = 5'd25;

  typedef enum logic [2:0] {IDLE, COLLECT, WAIT, ACCESS, EMIT} state_t;

  state_t                state_q;
  logic [24:0]           frm_q;      // {we, data, addr}
  logic [4:0]            bit_cnt_q;
  logic [3:0]            wait_cnt_q;
  logic [3:0]            emit_cnt_q;
  logic [15:0]           resp_sr_q;
  logic                  ovr_q;      // inside an overrun burst; cleared when ready drops
  logic [15:0]           mem_q [DEPTH];
`ifdef RESPONDER_STATS_EN
  logic [15:0]           rd_cnt_q;
  logic [15:0]           wr_cnt_q;
`endif

  logic [DEPTH_LOG2-1:0] idx;
  logic [15:0]           cur_word;
  logic [15:0]           new_word;
  logic                  unused_addr;

  // Address bits above the word index alias onto the same store.
  assign idx         = frm_q[DEPTH_LOG2:1];
  assign unused_addr = ^frm_q[15:0];
  assign cur_word    = mem_q[idx];

  always_comb begin
    new_word = cur_word;
    if (frm_q[24]) begin
      if (frm_q[0]) new_word[15:8] = frm_q[23:16];
      else          new_word[7:0]  = frm_q[23:16];
    end
  end

  always_ff @(posedge fast_clk or negedge reset) begin
    if (!reset) begin
      state_q               <= IDLE;
      frm_q                 <= '0;
      bit_cnt_q             <= '0;
      wait_cnt_q            <= '0;
      emit_cnt_q            <= '0;
      resp_sr_q             <= '0;
      ovr_q                 <= 1'b0;
      response_serial       <= 1'b0;
      response_serial_ready <= 1'b0;
      busy                  <= 1'b0;
      frame_error           <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
`ifdef RESPONDER_STATS_EN
      rd_cnt_q              <= '0;
      wr_cnt_q              <= '0;
`endif
    end else begin
      frame_error <= 1'b0;
      if (!request_serial_ready) ovr_q <= 1'b0;

      case (state_q)
        IDLE: begin
          // A burst still running from an overrun is a tail, not a new frame.
          if (request_serial_ready && !ovr_q) begin
            state_q   <= COLLECT;
            busy      <= 1'b1;
            frm_q     <= {request_serial, 24'd0};
            bit_cnt_q <= 5'd1;
          end
        end
        COLLECT: begin
          if (request_serial_ready) begin
            frm_q <= {request_serial, frm_q[24:1]};
            if (bit_cnt_q != 5'd31) bit_cnt_q <= bit_cnt_q + 5'd1;
          end else if (bit_cnt_q == FRAME_LEN) begin
            if (LAT == 4'd0) begin
              state_q <= ACCESS;
            end else begin
              state_q    <= WAIT;
              wait_cnt_q <= LAT - 4'd1;
            end
          end else begin
            state_q     <= IDLE;
            busy        <= 1'b0;
            frame_error <= 1'b1;
          end
        end
        WAIT: begin
          if (wait_cnt_q == 4'd0) state_q <= ACCESS;
          else                    wait_cnt_q <= wait_cnt_q - 4'd1;
        end
        ACCESS: begin
          if (frm_q[24]) mem_q[idx] <= new_word;
`ifdef RESPONDER_STATS_EN
          if (frm_q[24]) begin
            if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
          end else begin
            if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
          end
`endif
          response_serial       <= new_word[0];
          response_serial_ready <= 1'b1;
          resp_sr_q             <= {1'b0, new_word[15:1]};
          emit_cnt_q            <= 4'd0;
          state_q               <= EMIT;
        end
        EMIT: begin
          if (emit_cnt_q == 4'd15) begin
            state_q               <= IDLE;
            busy                  <= 1'b0;
            response_serial       <= 1'b0;
            response_serial_ready <= 1'b0;
          end else begin
            response_serial <= resp_sr_q[0];
            resp_sr_q       <= {1'b0, resp_sr_q[15:1]};
            emit_cnt_q      <= emit_cnt_q + 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase

      // Request traffic while a transaction is in flight is dropped; flag once per burst.
      if (request_serial_ready && (state_q == WAIT || state_q == ACCESS || state_q == EMIT)) begin
        ovr_q <= 1'b1;
        if (!ovr_q) frame_error <= 1'b1;
      end
    end
  end

`ifdef RESPONDER_STATS_EN
  assign read_count  = rd_cnt_q;
  assign write_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_serial_memory_responder.sv
// Scoreboard bench for serial_memory_responder: byte-addressed reference memory,
// expected words queued at issue time, a negedge monitor reassembles and compares.
module tb_serial_memory_responder;
  localparam int DL  = 8;
  localparam int LAT = 2;
  localparam int NB  = 1 << (DL + 1);

  logic        fast_clk = 1'b0;
  logic        reset = 1'b0;
  logic        request_serial = 1'b0;
  logic        request_serial_ready = 1'b0;
  logic        response_serial;
  logic        response_serial_ready;
  logic        busy;
  logic        frame_error;
`ifdef RESPONDER_STATS_EN
  logic [15:0] read_count;
  logic [15:0] write_count;
`endif

  serial_memory_responder #(.DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
    .fast_clk              (fast_clk),
    .reset                 (reset),
    .request_serial        (request_serial),
    .request_serial_ready  (request_serial_ready),
    .response_serial       (response_serial),
    .response_serial_ready (response_serial_ready),
    .busy                  (busy),
    .frame_error           (frame_error)
`ifdef RESPONDER_STATS_EN
    ,
    .read_count            (read_count),
    .write_count           (write_count)
`endif
  );

  always #5 fast_clk = ~fast_clk;

  typedef struct {
    logic [15:0] w;
    int          t;
  } exp_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          err_cnt = 0;
  int          run = 0;
  int          first_cyc = 0;
  logic [15:0] acc;
  byte unsigned mem_m [NB];
  exp_t        exp_q[$];

  always @(posedge fast_clk) cyc <= cyc + 1;

  task automatic note_fail(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    bad++;
    $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: assemble 16-bit responses and compare against the queue head.
  always @(negedge fast_clk) begin
    exp_t e;
    if (frame_error === 1'b1) err_cnt++;
    if (!reset) begin
      run = 0;
    end else if (response_serial_ready === 1'b1) begin
      if (run == 0) first_cyc = cyc;
      acc[run] = response_serial;
      run++;
      if (run == 16) begin
        run = 0;
        if (exp_q.size() == 0) begin
          note_fail("unexpected_resp", acc, 0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_word", acc, e.w);
          chk("resp_latency", first_cyc, e.t);
        end
      end
    end else begin
      chk("quiet_serial_zero", response_serial, 0);
      if (run != 0) begin
        note_fail("short_burst", run, 16);
        run = 0;
      end
    end
  end

  task automatic send_bits(input logic [31:0] bits, input int n, output int end_cyc);
    for (int i = 0; i < n; i++) begin
      @(posedge fast_clk); #1;
      request_serial_ready = 1'b1;
      request_serial       = bits[i];
    end
    @(posedge fast_clk); #1;
    request_serial_ready = 1'b0;
    request_serial       = 1'b0;
    end_cyc = cyc;
  endtask

  function automatic logic [15:0] model_word(input logic [15:0] a);
    int lo;
    lo = (int'(a) % NB) & ~1;
    return {mem_m[lo + 1], mem_m[lo]};
  endfunction

  task automatic xact(input logic we, input logic [15:0] a, input logic [7:0] d);
    int   ec;
    exp_t e;
    send_bits({7'd0, we, d, a}, 25, ec);
    if (we) mem_m[int'(a) % NB] = d;
    e.w = model_word(a);
    e.t = ec + LAT + 2;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || run != 0 || busy !== 1'b0) && n < 300) begin
      @(negedge fast_clk); #1;
      n++;
    end
    if (n >= 300) note_fail("idle_timeout", n, 300);
    repeat (2) @(negedge fast_clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=%0d required=0", cyc);
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1);
  end

  initial begin
    int e0, ec, n, hi;
    for (int i = 0; i < NB; i++) mem_m[i] = 8'h00;

    repeat (3) @(negedge fast_clk);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", response_serial_ready, 0);
    chk("rst_ser", response_serial, 0);
    chk("rst_ferr", frame_error, 0);
    reset = 1'b1;
    repeat (2) @(negedge fast_clk);
    chk("post_rst_busy", busy, 0);

    // read after reset, then byte writes into one word and a read back
    xact(1'b0, 16'h0017, 8'h00);   wait_idle();
    xact(1'b1, 16'h0017, 8'h10);   wait_idle();
    xact(1'b1, 16'h0016, 8'h19);   wait_idle();
    xact(1'b0, 16'h0016, 8'h00);   wait_idle();
    chk("word_16", model_word(16'h0016), 16'h1019);

    // short and long frames are discarded
    e0 = err_cnt;
    send_bits({7'd0, 1'b1, 8'hEE, 16'h0016}, 24, ec); wait_idle();
    chk("ferr_24", err_cnt - e0, 1);
    e0 = err_cnt;
    send_bits({6'd0, 1'b0, 1'b1, 8'hEE, 16'h0017}, 26, ec); wait_idle();
    chk("ferr_26", err_cnt - e0, 1);
    xact(1'b0, 16'h0016, 8'h00); wait_idle();

    // overrun frame during EMIT is dropped along with its tail
    e0 = err_cnt;
    xact(1'b0, 16'h0016, 8'h00);
    n = 0;
    while (response_serial_ready !== 1'b1 && n < 100) begin @(negedge fast_clk); #1; n++; end
    if (n >= 100) note_fail("emit_wait", n, 100);
    repeat (3) @(negedge fast_clk);
    send_bits({7'd0, 1'b1, 8'h55, 16'h0016}, 25, ec);
    wait_idle();
    chk("ferr_overrun", err_cnt - e0, 1);
    xact(1'b0, 16'h0016, 8'h00); wait_idle();

    // aliasing of high address bits
    xact(1'b1, 16'hFE00, 8'hAB); wait_idle();
    xact(1'b0, 16'h0000, 8'h00); wait_idle();
    chk("alias_word0", model_word(16'h0000), 16'h00AB);

    for (int k = 0; k < 40; k++) begin
      xact(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom));
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge fast_clk);
    end

    // reset at the 8th response bit aborts the stream
    send_bits({7'd0, 1'b0, 8'h00, 16'h0016}, 25, ec);
    n = 0;
    while (run != 8 && n < 200) begin @(negedge fast_clk); #1; n++; end
    if (n >= 200) note_fail("abort_wait", n, 200);
    reset = 1'b0;
    #1;
    chk("abort_rdy", response_serial_ready, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ser", response_serial, 0);
    for (int i = 0; i < NB; i++) mem_m[i] = 8'h00;
    repeat (3) @(negedge fast_clk);
    reset = 1'b1;
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge fast_clk); #1;
      if (response_serial_ready === 1'b1) hi++;
    end
    chk("post_abort_bits", hi, 0);

    // store cleared by reset; three reads and two writes
    xact(1'b0, 16'h0017, 8'h00); wait_idle();
    xact(1'b1, 16'h0020, 8'h5A); wait_idle();
    xact(1'b0, 16'h0020, 8'h00); wait_idle();
    xact(1'b1, 16'h0021, 8'hC3); wait_idle();
    xact(1'b0, 16'h0020, 8'h00); wait_idle();
`ifdef RESPONDER_STATS_EN
    chk("read_count", read_count, 3);
    chk("write_count", write_count, 2);
`endif
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_memory_responder.md
SERIAL_MEMORY_RESPONDER -- requirements
Module: serial_memory_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 8, meaning log2 of the number of 16-bit words in the backing store.
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning wait cycles (0..15) between request frame end and store access.
REQ-003 The block SHALL have port fast_clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port request_serial, input, 1 bit, request bit stream, LSB first.
REQ-006 The block SHALL have port request_serial_ready, input, 1 bit, high for every cycle that request_serial carries a valid bit.
REQ-007 The block SHALL have port response_serial, output, 1 bit, response bit stream, LSB first.
REQ-008 The block SHALL have port response_serial_ready, output, 1 bit, high for every cycle that response_serial carries a valid bit.
REQ-009 The block SHALL have port busy, output, 1 bit, high in every state except IDLE.
REQ-010 The block SHALL have port frame_error, output, 1 bit, one-cycle pulse when a malformed or overrun frame is discarded.

Function
REQ-011 A request frame SHALL be 25 bits {we[24], data[23:16], addr[15:0]}, delivered on consecutive cycles with request_serial_ready high.
REQ-012 States SHALL be IDLE, COLLECT, WAIT, ACCESS, EMIT.
REQ-013 IDLE->COLLECT SHALL occur on the first cycle request_serial_ready is high, and that cycle's bit SHALL be captured as bit 0.
REQ-014 COLLECT SHALL shift in one bit per ready-high cycle, with the bit counter saturating at 31.
REQ-015 When ready falls with exactly 25 bits counted, the next state SHALL be WAIT; any other count SHALL go to IDLE with a frame_error pulse and no store access.
REQ-016 WAIT SHALL last exactly LATENCY cycles; LATENCY=0 SHALL go directly to ACCESS.
REQ-017 ACCESS (1 cycle) SHALL use word index addr[DEPTH_LOG2:1], ignore higher address bits (aliasing), and write data to the low byte if addr[0]=0 or the high byte if addr[0]=1 when we=1.
REQ-018 The response word SHALL be the full 16-bit word after any write in the same ACCESS (write-then-read), for both reads and writes.
REQ-019 EMIT SHALL drive response_serial_ready high for exactly 16 consecutive cycles, bit 0 first, then return to IDLE.
REQ-020 response_serial SHALL be 0 whenever response_serial_ready is low.
REQ-021 Latency SHALL be: the first response bit appears LATENCY+2 cycles after the first cycle with request_serial_ready low.
REQ-022 request_serial_ready high during WAIT, ACCESS or EMIT SHALL be ignored, SHALL cause a single frame_error pulse per overrun burst, and SHALL NOT disturb the in-flight transaction.
REQ-023 After EMIT, if request_serial_ready is already high, those bits SHALL be treated as an overrun tail and dropped until ready goes low; only a fresh rising ready in IDLE starts a frame.

Reset
REQ-024 Reset low SHALL immediately force state IDLE and drive response_serial=0, response_serial_ready=0, busy=0 and frame_error=0.
REQ-025 Reset low SHALL clear the shift registers, the counters and every backing-store word to 0.
REQ-026 Reset asserted mid-frame or mid-EMIT SHALL abort the transaction with no partial write and no further response bits after release.

Configuration
REQ-027 With macro RESPONDER_STATS_EN defined, outputs read_count[15:0] and write_count[15:0] SHALL exist, increment in ACCESS on we=0 and we=1 respectively, saturate at 16'hFFFF, and reset to 0.
REQ-028 Without RESPONDER_STATS_EN, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Bench SHALL check: after reset, a read of addr 16'h0017 -> response 16'h0000, with the first response bit at cycle LATENCY+2 after the frame ends, and ready high for 16 cycles.
REQ-030 Bench SHALL check: write 8'h10 to 16'h0017, then write 8'h19 to 16'h0016 -> responses 16'h1000 then 16'h1019, and a later read of 16'h0016 -> 16'h1019.
REQ-031 Bench SHALL check: a 24-bit frame and a 26-bit frame -> one frame_error pulse each, no response, and store unchanged.
REQ-032 Bench SHALL check: a new frame sent during EMIT -> single frame_error pulse, and the original 16-bit response is intact.
REQ-033 Bench SHALL check: DEPTH_LOG2=8, write 8'hAB to 16'hFE00, then read 16'h0000 -> 16'h00AB (aliasing).
REQ-034 Bench SHALL check: reset pulse at the 8th response bit -> ready falls immediately, no further bits; with RESPONDER_STATS_EN, after 3 reads and 2 writes -> read_count=3 and write_count=2.
